// File: rtl/nios_system_sysid_checker.sv
// rtl/nios_system_sysid_checker.sv - Avalon-MM reader that checks the system ID and build timestamp words
// Optional per-read stall timeout is built when SYSID_CHECKER_TIMEOUT_EN is defined.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1579707414,
    parameter int          READ_LATENCY   = 0
`ifdef SYSID_CHECKER_TIMEOUT_EN
   ,parameter int          TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_CMP, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_lat;
    logic        r_id_chk;
    logic        r_ts_chk;
    logic        w_accept;
    logic        w_in_rd;
    logic        w_lat_hit;
    logic        w_start_ok;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic        w_tmo;
    logic        w_read_d;
    logic        w_addr_d;
    logic        w_busy_d;
    logic        w_done_d;
    logic        w_pass_d;
    logic        w_id_ok_d;
    logic        w_ts_ok_d;
    logic        w_tmo_d;
    logic [31:0] w_id_value_d;
    logic [31:0] w_ts_value_d;

    assign w_accept   = avm_read & ~avm_waitrequest;
    assign w_in_rd    = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_lat_hit  = (READ_LATENCY > 0) && (int'(r_lat) == READ_LATENCY - 1);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cap_id   = (READ_LATENCY == 0) ? ((r_state == S_RD_ID) && w_accept)
                                            : ((r_state == S_LAT_ID) && w_lat_hit);
    assign w_cap_ts   = (READ_LATENCY == 0) ? ((r_state == S_RD_TS) && w_accept)
                                            : ((r_state == S_LAT_TS) && w_lat_hit);

`ifdef SYSID_CHECKER_TIMEOUT_EN
    // Stall count restarts from zero whenever a read is not being stalled.
    logic [15:0] r_stall;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (w_in_rd && avm_read && avm_waitrequest) begin
            if (r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
        end else begin
            r_stall <= '0;
        end
    end
    assign w_tmo = w_in_rd && avm_read && avm_waitrequest
                && (({16'd0, r_stall} + 32'd1) >= 32'(TIMEOUT_CYCLES));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_lat       <= 2'd0;
            r_id_chk    <= 1'b0;
            r_ts_chk    <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            r_state     <= w_next;
            r_lat       <= ((r_state == S_LAT_ID) || (r_state == S_LAT_TS)) ? r_lat + 2'd1 : 2'd0;
            r_id_chk    <= w_cap_id;
            r_ts_chk    <= w_cap_ts;
            avm_read    <= w_read_d;
            avm_address <= w_addr_d;
            busy        <= w_busy_d;
            done        <= w_done_d;
            pass        <= w_pass_d;
            id_ok       <= w_id_ok_d;
            ts_ok       <= w_ts_ok_d;
            timeout     <= w_tmo_d;
            id_value    <= w_id_value_d;
            ts_value    <= w_ts_value_d;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_RD_ID;
            S_RD_ID: begin
                if (w_tmo)         w_next = S_DONE;
                else if (w_accept) w_next = (READ_LATENCY == 0) ? S_RD_TS : S_LAT_ID;
            end
            S_LAT_ID: if (w_lat_hit) w_next = S_RD_TS;
            S_RD_TS: begin
                if (w_tmo)         w_next = S_DONE;
                else if (w_accept) w_next = (READ_LATENCY == 0) ? S_CMP : S_LAT_TS;
            end
            S_LAT_TS: if (w_lat_hit) w_next = S_CMP;
            S_CMP:    w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; a fresh start wipes the previous result.
    always_comb begin
        w_read_d     = (w_next == S_RD_ID) || (w_next == S_RD_TS);
        w_addr_d     = (w_next == S_RD_TS);
        w_busy_d     = (w_next != S_IDLE) && (w_next != S_DONE);
        w_done_d     = (w_next == S_DONE);
        w_id_value_d = w_start_ok ? 32'd0 : (w_cap_id ? avm_readdata : id_value);
        w_ts_value_d = w_start_ok ? 32'd0 : (w_cap_ts ? avm_readdata : ts_value);
        w_id_ok_d    = w_start_ok ? 1'b0 : (r_id_chk ? (id_value == EXPECTED_ID) : id_ok);
        w_ts_ok_d    = w_start_ok ? 1'b0 : (r_ts_chk ? (ts_value == EXPECTED_TS) : ts_ok);
        w_tmo_d      = w_start_ok ? 1'b0 : (w_tmo | timeout);
        w_pass_d     = pass;
        if (w_start_ok || w_tmo)  w_pass_d = 1'b0;
        else if (r_state == S_CMP) w_pass_d = id_ok & (ts_value == EXPECTED_TS) & ~timeout;
    end
endmodule
